// File: rtl/regfile_dbg_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dbg_ctrl_pkg
// Brief    : Shared state encodings and constants for the regfile debug ctrl.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_dbg_ctrl_pkg;

  localparam int DEF_NREG = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Debug write FSM
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_PEND = 2'd1;
  localparam logic [1:0] W_ACK  = 2'd2;

  // Register dump FSM
  localparam logic [1:0] D_IDLE = 2'd0;
  localparam logic [1:0] D_READ = 2'd1;
  localparam logic [1:0] D_OUT  = 2'd2;
  localparam logic [1:0] D_DONE = 2'd3;

endpackage : regfile_dbg_ctrl_pkg
`default_nettype wire

// File: rtl/regfile_dbg_ctrl_dump_seq.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump_seq
// Brief    : Walks the regfile debug read port and streams every register out
//            over a valid/ready handshake, bypassing a same-cycle write.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_dump_seq
  import regfile_dbg_ctrl_pkg::*;
#(
  parameter int NREG = DEF_NREG
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dump_start,
  input  logic        dump_ready,
  input  logic [31:0] reg_content,
  input  logic        rf_wreg,
  input  logic [4:0]  rf_destR,
  input  logic [31:0] rf_dest,
  output logic [4:0]  which_reg,
  output logic        dump_valid,
  output logic [4:0]  dump_idx,
  output logic [31:0] dump_data,
  output logic        dump_done,
  output logic        dump_busy
);

  localparam logic [4:0] c_last_idx = 5'(NREG - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic [4:0]  r_idx;
  logic [31:0] r_data;
  logic        w_accept;
  logic        w_last;
  logic        w_bypass;

  assign w_accept = (r_state == D_OUT) && dump_ready;
  assign w_last   = (r_idx == c_last_idx);
  // The regfile commits at the same edge we sample it, so take the write data
  assign w_bypass = rf_wreg && (rf_destR == r_idx) && (r_idx != REG_ZERO);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= D_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      D_IDLE:  if (dump_start) w_state_next = D_READ;
      D_READ:  w_state_next = D_OUT;
      D_OUT:   if (w_accept) w_state_next = w_last ? D_DONE : D_READ;
      D_DONE:  w_state_next = D_IDLE;
      default: w_state_next = D_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx  <= REG_ZERO;
      r_data <= '0;
    end else begin
      if (r_state == D_IDLE && dump_start) begin
        r_idx <= REG_ZERO;
      end
      if (r_state == D_READ) begin
        r_data <= w_bypass ? rf_dest : reg_content;
      end
      if (w_accept && !w_last) begin
        r_idx <= r_idx + 5'd1;
      end
    end
  end

  always_comb begin
    which_reg  = (r_state == D_READ) ? r_idx : REG_ZERO;
    dump_valid = (r_state == D_OUT);
    dump_idx   = (r_state == D_OUT) ? r_idx : REG_ZERO;
    dump_data  = (r_state == D_OUT) ? r_data : 32'd0;
    dump_done  = (r_state == D_DONE);
    dump_busy  = (r_state != D_IDLE);
  end

endmodule : regfile_dump_seq
`default_nettype wire

// File: rtl/regfile_dbg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dbg_ctrl
// Brief    : Shares the regfile write port between WB and a debug host, with
//            starvation stall, and sequences a full register dump.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_dbg_ctrl
  import regfile_dbg_ctrl_pkg::*;
#(
  parameter int NREG     = DEF_NREG,
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_wreg,
  input  logic [4:0]  wb_destR,
  input  logic [31:0] wb_dest,
  output logic        rf_wreg,
  output logic [4:0]  rf_destR,
  output logic [31:0] rf_dest,
  input  logic        dbg_wr_req,
  input  logic [4:0]  dbg_wr_addr,
  input  logic [31:0] dbg_wr_data,
  output logic        dbg_wr_busy,
  output logic        dbg_wr_ack,
  output logic        dbg_stall,
  output logic [4:0]  which_reg,
  input  logic [31:0] reg_content,
  input  logic        dump_start,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [4:0]  dump_idx,
  output logic [31:0] dump_data,
  output logic        dump_done,
  output logic        dump_busy
);

  localparam logic [3:0] c_stall_at = 4'(MAX_WAIT - 1);
  localparam logic [3:0] c_wait_max = 4'd15;

  logic [1:0]  r_wstate;
  logic [1:0]  w_wstate_next;
  logic [4:0]  r_wr_addr;
  logic [31:0] r_wr_data;
  logic [3:0]  r_wait_cnt;
  logic        r_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate <= W_IDLE;
    end else begin
      r_wstate <= w_wstate_next;
    end
  end

  always_comb begin
    w_wstate_next = r_wstate;
    case (r_wstate)
      W_IDLE:  if (dbg_wr_req) w_wstate_next = W_PEND;
      W_PEND:  if (!wb_wreg) w_wstate_next = W_ACK;
      W_ACK:   w_wstate_next = W_IDLE;
      default: w_wstate_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_addr  <= REG_ZERO;
      r_wr_data  <= '0;
      r_wait_cnt <= '0;
      r_stall    <= 1'b0;
    end else begin
      if (r_wstate == W_IDLE && dbg_wr_req) begin
        r_wr_addr  <= dbg_wr_addr;
        r_wr_data  <= dbg_wr_data;
        r_wait_cnt <= '0;
      end
      if (r_wstate == W_PEND) begin
        if (wb_wreg) begin
          if (r_wait_cnt != c_wait_max) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
          end
          if (r_wait_cnt == c_stall_at) begin
            r_stall <= 1'b1;
          end
        end else begin
          // Write lands this cycle; release the pipeline as we enter W_ACK
          r_stall <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    rf_wreg     = 1'b0;
    rf_destR    = REG_ZERO;
    rf_dest     = 32'd0;
    dbg_wr_busy = (r_wstate == W_PEND) || (r_wstate == W_ACK);
    dbg_wr_ack  = (r_wstate == W_ACK);
    dbg_stall   = r_stall;
    if (wb_wreg) begin
      rf_wreg  = 1'b1;
      rf_destR = wb_destR;
      rf_dest  = wb_dest;
    end else if (r_wstate == W_PEND) begin
      rf_wreg  = (r_wr_addr != REG_ZERO);
      rf_destR = r_wr_addr;
      rf_dest  = r_wr_data;
    end
  end

  regfile_dump_seq #(
    .NREG (NREG)
  ) u_dump_seq (
    .clk         (clk),
    .rst         (rst),
    .dump_start  (dump_start),
    .dump_ready  (dump_ready),
    .reg_content (reg_content),
    .rf_wreg     (rf_wreg),
    .rf_destR    (rf_destR),
    .rf_dest     (rf_dest),
    .which_reg   (which_reg),
    .dump_valid  (dump_valid),
    .dump_idx    (dump_idx),
    .dump_data   (dump_data),
    .dump_done   (dump_done),
    .dump_busy   (dump_busy)
  );

endmodule : regfile_dbg_ctrl
`default_nettype wire

// File: tb/tb_regfile_dbg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_dbg_ctrl
// Brief    : Randomized bench with a transaction-level reference model of the
//            write-port sharing and register dump.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_dbg_ctrl;

  localparam int NREG     = 32;
  localparam int MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_wreg = 1'b0;
  logic [4:0]  wb_destR = '0;
  logic [31:0] wb_dest = '0;
  logic        rf_wreg;
  logic [4:0]  rf_destR;
  logic [31:0] rf_dest;
  logic        dbg_wr_req = 1'b0;
  logic [4:0]  dbg_wr_addr = '0;
  logic [31:0] dbg_wr_data = '0;
  logic        dbg_wr_busy, dbg_wr_ack, dbg_stall;
  logic [4:0]  which_reg;
  logic [31:0] reg_content;
  logic        dump_start = 1'b0;
  logic        dump_valid;
  logic        dump_ready = 1'b0;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;
  logic        dump_done, dump_busy;

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;

  regfile_dbg_ctrl #(.NREG(NREG), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .wb_wreg(wb_wreg), .wb_destR(wb_destR), .wb_dest(wb_dest),
    .rf_wreg(rf_wreg), .rf_destR(rf_destR), .rf_dest(rf_dest),
    .dbg_wr_req(dbg_wr_req), .dbg_wr_addr(dbg_wr_addr), .dbg_wr_data(dbg_wr_data),
    .dbg_wr_busy(dbg_wr_busy), .dbg_wr_ack(dbg_wr_ack), .dbg_stall(dbg_stall),
    .which_reg(which_reg), .reg_content(reg_content),
    .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_idx(dump_idx), .dump_data(dump_data), .dump_done(dump_done),
    .dump_busy(dump_busy)
  );

  always #5 clk = ~clk;

  // Environment regfile: written by the DUT write port, r0 reads as zero
  logic [31:0] env_rf [32];
  assign reg_content = (which_reg == 5'd0) ? 32'd0 : env_rf[which_reg];
  always @(posedge clk) begin
    if (!started) begin
      for (int i = 0; i < 32; i++) env_rf[i] <= 32'd0;
    end else if (rf_wreg && rf_destR != 5'd0) begin
      env_rf[rf_destR] <= rf_dest;
    end
  end

  // Reference model: what the registers must hold and what each side owes
  logic [31:0] gold_rf [32];
  bit          m_pend, m_ack, old_busy;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_lost;
  bit          m_dbusy, m_show, m_ddone;
  int          m_idx;
  logic [31:0] m_word;

  always @(posedge clk) begin
    if (!started) begin
      for (int i = 0; i < 32; i++) gold_rf[i] = 32'd0;
      m_pend = 0; m_ack = 0; m_lost = 0; m_addr = '0; m_data = '0;
      m_dbusy = 0; m_show = 0; m_ddone = 0; m_idx = 0; m_word = '0;
    end else begin
      if (wb_wreg) begin
        if (wb_destR != 5'd0) gold_rf[wb_destR] = wb_dest;
      end else if (m_pend && m_addr != 5'd0) begin
        gold_rf[m_addr] = m_data;
      end
      if (rst) begin
        m_pend = 0; m_ack = 0; m_lost = 0;
        m_dbusy = 0; m_show = 0; m_ddone = 0; m_idx = 0;
      end else begin
        old_busy = m_pend || m_ack;
        m_ack = 0;
        if (m_pend) begin
          if (!wb_wreg) begin m_pend = 0; m_ack = 1; end
          else m_lost++;
        end else if (!old_busy && dbg_wr_req) begin
          m_pend = 1; m_addr = dbg_wr_addr; m_data = dbg_wr_data; m_lost = 0;
        end
        if (m_ddone) begin
          m_ddone = 0; m_dbusy = 0;
        end else if (m_dbusy) begin
          if (!m_show) begin
            m_show = 1; m_word = gold_rf[m_idx];
          end else if (dump_ready) begin
            m_show = 0;
            if (m_idx == NREG - 1) m_ddone = 1;
            else m_idx++;
          end
        end else if (dump_start) begin
          m_dbusy = 1; m_idx = 0; m_show = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  logic [31:0] got [32];
  int          xfer_cnt = 0;
  int          done_cnt = 0;
  bit          p_valid = 0, p_ready = 0, p_rst = 1;
  logic [4:0]  p_idx = '0;
  logic [31:0] p_data = '0;

  always @(negedge clk) begin
    if (started) begin
      logic        e_wreg;
      logic [4:0]  e_destR;
      logic [31:0] e_dest;
      if (wb_wreg) begin
        e_wreg = 1; e_destR = wb_destR; e_dest = wb_dest;
      end else if (m_pend) begin
        e_wreg = (m_addr != 5'd0); e_destR = m_addr; e_dest = m_data;
      end else begin
        e_wreg = 0; e_destR = '0; e_dest = '0;
      end
      chk("rf_wreg", 32'(rf_wreg), 32'(e_wreg));
      chk("rf_destR", 32'(rf_destR), 32'(e_destR));
      chk("rf_dest", rf_dest, e_dest);
      chk("dbg_wr_busy", 32'(dbg_wr_busy), 32'(m_pend || m_ack));
      chk("dbg_wr_ack", 32'(dbg_wr_ack), 32'(m_ack));
      chk("dbg_stall", 32'(dbg_stall), 32'(m_pend && (m_lost >= MAX_WAIT)));
      chk("dump_busy", 32'(dump_busy), 32'(m_dbusy));
      chk("dump_valid", 32'(dump_valid), 32'(m_dbusy && m_show));
      chk("dump_done", 32'(dump_done), 32'(m_ddone));
      if (m_dbusy && m_show) begin
        chk("dump_idx", 32'(dump_idx), 32'(m_idx));
        chk("dump_data", dump_data, m_word);
      end
      if (m_dbusy && !m_show && !m_ddone) chk("which_reg", 32'(which_reg), 32'(m_idx));
      if (p_valid && !p_ready && !p_rst) begin
        chk("hold_valid", 32'(dump_valid), 32'd1);
        chk("hold_idx", 32'(dump_idx), 32'(p_idx));
        chk("hold_data", dump_data, p_data);
      end
      if (dump_valid && dump_ready) begin
        got[dump_idx] = dump_data;
        xfer_cnt++;
      end
      if (dump_done) done_cnt++;
      p_valid = dump_valid; p_ready = dump_ready; p_rst = rst;
      p_idx = dump_idx; p_data = dump_data;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rf_wreg"}, 32'(rf_wreg), 0);
    chk({tag, "_rf_destR"}, 32'(rf_destR), 0);
    chk({tag, "_rf_dest"}, rf_dest, 0);
    chk({tag, "_busy"}, 32'(dbg_wr_busy), 0);
    chk({tag, "_ack"}, 32'(dbg_wr_ack), 0);
    chk({tag, "_stall"}, 32'(dbg_stall), 0);
    chk({tag, "_which_reg"}, 32'(which_reg), 0);
    chk({tag, "_dump_valid"}, 32'(dump_valid), 0);
    chk({tag, "_dump_idx"}, 32'(dump_idx), 0);
    chk({tag, "_dump_data"}, dump_data, 0);
    chk({tag, "_dump_done"}, 32'(dump_done), 0);
    chk({tag, "_dump_busy"}, 32'(dump_busy), 0);
  endtask

  // mode 0: ready held 1; mode 1: 1,1,0 pattern; mode 2: random
  task automatic run_dump(input int mode, output int busy_cycles);
    bit seen_done = 0;
    xfer_cnt = 0; done_cnt = 0; busy_cycles = 0;
    dump_start = 1; cyc(); dump_start = 0;
    for (int k = 0; k < 400; k++) begin
      dump_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((k % 3) != 2) : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (dump_done) begin seen_done = 1; break; end
      if (dump_busy) busy_cycles++;
      cyc();
    end
    if (!seen_done) chk("dump_timeout", 0, 1);
    cyc();
    dump_ready = 0;
    chk("dump_xfers", xfer_cnt, 32);
    chk("dump_done_pulses", done_cnt, 1);
  endtask

  task automatic dbg_write(input logic [4:0] a, input logic [31:0] d);
    dbg_wr_req = 1; dbg_wr_addr = a; dbg_wr_data = d;
    cyc();
    dbg_wr_req = 0;
  endtask

  initial begin
    int bc;
    int lost;
    bit hit;
    int burst;

    rst = 1;
    cyc();
    started = 1;
    cyc(); cyc();
    @(negedge clk);
    chk_all_zero("reset");
    cyc();
    rst = 0;
    cyc();

    // Best-case debug write, then dump to see it
    dbg_write(5'd5, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_rf_wreg", 32'(rf_wreg), 1);
    chk("t1_rf_destR", 32'(rf_destR), 5);
    chk("t1_rf_dest", rf_dest, 32'hDEADBEEF);
    cyc();
    @(negedge clk);
    chk("t1_ack", 32'(dbg_wr_ack), 1);
    cyc(); cyc();
    run_dump(0, bc);
    chk("t1_dump_word5", got[5], 32'hDEADBEEF);
    chk("dump_64_cycles", bc, 64);

    // Starvation: WB owns the port
    wb_wreg = 1; wb_destR = 5'd3; wb_dest = 32'hA5A50003;
    dbg_write(5'd7, 32'h00000777);
    lost = 0; hit = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (dbg_stall) begin hit = 1; break; end
      lost++;
      cyc();
    end
    chk("stall_seen", 32'(hit), 1);
    chk("stall_after_lost", lost, MAX_WAIT);
    chk("stall_wb_destR", 32'(rf_destR), 3);
    cyc(); cyc();
    wb_wreg = 0;
    @(negedge clk);
    chk("starve_commit_wreg", 32'(rf_wreg), 1);
    chk("starve_commit_destR", 32'(rf_destR), 7);
    chk("starve_commit_dest", rf_dest, 32'h00000777);
    chk("starve_stall_held", 32'(dbg_stall), 1);
    cyc();
    @(negedge clk);
    chk("starve_ack", 32'(dbg_wr_ack), 1);
    chk("starve_stall_clear", 32'(dbg_stall), 0);
    cyc(); cyc();

    // Write to r0
    dbg_write(5'd0, 32'd1);
    @(negedge clk);
    chk("r0_no_wreg", 32'(rf_wreg), 0);
    cyc();
    @(negedge clk);
    chk("r0_ack", 32'(dbg_wr_ack), 1);
    chk("r0_no_wreg2", 32'(rf_wreg), 0);
    cyc(); cyc();

    // Preload r1..r31 = index*4, then dump with a stuttering host
    for (int i = 1; i < 32; i++) begin
      wb_wreg = 1; wb_destR = 5'(i); wb_dest = 32'(i * 4);
      cyc();
    end
    wb_wreg = 0;
    cyc();
    run_dump(1, bc);
    for (int i = 0; i < 32; i++) chk($sformatf("preload_word%0d", i), got[i], 32'(i * 4));

    // WB write hits the register in its read cycle
    hit = 0;
    dump_start = 1; cyc(); dump_start = 0; dump_ready = 1;
    done_cnt = 0;
    for (int k = 0; k < 200; k++) begin
      if (which_reg == 5'd9 && dump_busy && !hit) begin
        wb_wreg = 1; wb_destR = 5'd9; wb_dest = 32'h12345678; hit = 1;
      end else begin
        wb_wreg = 0;
      end
      @(negedge clk);
      if (dump_done) break;
      cyc();
    end
    cyc();
    wb_wreg = 0;
    chk("bypass_injected", 32'(hit), 1);
    chk("bypass_word9", got[9], 32'h12345678);

    // Reset in W_PEND and mid-dump
    wb_wreg = 1; wb_destR = 5'd2; wb_dest = 32'h22;
    dbg_wr_req = 1; dbg_wr_addr = 5'd4; dbg_wr_data = 32'h44;
    dump_start = 1; dump_ready = 1;
    cyc();
    dbg_wr_req = 0; dump_start = 0;
    hit = 0;
    for (int k = 0; k < 200; k++) begin
      cyc();
      if (which_reg == 5'd12 && dump_busy) begin hit = 1; break; end
    end
    chk("rst_reached_idx12", 32'(hit), 1);
    chk("rst_write_pending", 32'(dbg_wr_busy), 1);
    rst = 1; wb_wreg = 0;
    cyc();
    rst = 0;
    @(negedge clk);
    chk_all_zero("midrst");
    for (int k = 0; k < 4; k++) begin
      cyc();
      @(negedge clk);
      chk("midrst_no_ack", 32'(dbg_wr_ack), 0);
      chk("midrst_no_done", 32'(dump_done), 0);
    end
    cyc();
    dump_start = 1; cyc(); dump_start = 0;
    cyc();
    @(negedge clk);
    chk("fresh_valid", 32'(dump_valid), 1);
    chk("fresh_idx0", 32'(dump_idx), 0);
    hit = 0;
    for (int k = 0; k < 200; k++) begin
      cyc();
      @(negedge clk);
      if (dump_done) begin hit = 1; break; end
    end
    chk("fresh_done", 32'(hit), 1);
    cyc(); cyc();

    // Randomized traffic
    burst = 0;
    for (int k = 0; k < 4000; k++) begin
      if (burst == 0) burst = $urandom_range(0, 1) ? $urandom_range(1, 14) : -$urandom_range(1, 6);
      wb_wreg = (burst > 0);
      if (burst > 0) burst--; else burst++;
      wb_destR = 5'($urandom_range(0, 31));
      wb_dest = $urandom;
      dbg_wr_req = ($urandom_range(0, 5) == 0);
      dbg_wr_addr = 5'($urandom_range(0, 31));
      dbg_wr_data = $urandom;
      dump_start = ($urandom_range(0, 29) == 0);
      dump_ready = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 699) == 0);
      cyc();
    end
    wb_wreg = 0; dbg_wr_req = 0; dump_start = 0; dump_ready = 1; rst = 0;
    for (int k = 0; k < 80; k++) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_regfile_dbg_ctrl
`default_nettype wire

// File: doc/regfile_dbg_ctrl.md
Name: regfile_dbg_ctrl

Overview:
- Shares the register file's single write port between the pipeline writeback (WB) path and a debug host.
- Sequences a full 32-register dump through the regfile debug read port (which_reg/reg_content) using a valid/ready handshake.
- Sits between the WB stage, the ID-stage regfile and the board debug/UART logic.
- WB always wins the write port. A starved debug write raises a stall request that freezes the pipeline until the write lands.

Parameters:
- NREG, 32, number of architectural registers dumped (indices 0..NREG-1).
- MAX_WAIT, 8, cycles a pending debug write may lose arbitration before dbg_stall asserts (1..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- wb_wreg  in  1  WB write enable.
- wb_destR  in  5  WB destination register.
- wb_dest  in  32  WB write data.
- rf_wreg  out  1  regfile write enable.
- rf_destR  out  5  regfile write address.
- rf_dest  out  32  regfile write data.
- dbg_wr_req  in  1  one-cycle debug write strobe.
- dbg_wr_addr  in  5  debug write address.
- dbg_wr_data  in  32  debug write data.
- dbg_wr_busy  out  1  debug write pending; new strobes are ignored while high.
- dbg_wr_ack  out  1  one-cycle pulse: debug write committed.
- dbg_stall  out  1  freeze request to the pipeline (ORed into the stall path).
- which_reg  out  5  regfile debug read address.
- reg_content  in  32  regfile debug read data (combinational).
- dump_start  in  1  one-cycle dump request.
- dump_valid  out  1  dump word valid.
- dump_ready  in  1  host accepts the dump word.
- dump_idx  out  5  index of the current dump word.
- dump_data  out  32  current dump word.
- dump_done  out  1  one-cycle pulse after the last word is accepted.
- dump_busy  out  1  dump in progress.

Behaviour:
- Reset: all FSMs idle, counters 0. Every output is 0 (rf_* 0, which_reg 0, dump_* 0, ack/stall/busy 0). A pending debug write or dump in progress is dropped without ack or done.
- Write-port mux (combinational):
  - wb_wreg=1: rf_* = WB inputs.
  - else, write FSM in W_PEND: rf_wreg=1 (0 if latched addr==0), rf_destR/rf_dest = latched values.
  - else all rf_* = 0.
- Write FSM states: W_IDLE, W_PEND, W_ACK.
  - W_IDLE: dbg_wr_req=1 latches addr/data, clears wait_cnt, moves to W_PEND.
  - W_PEND, wb_wreg=0: the write commits this cycle; next state W_ACK.
  - W_PEND, wb_wreg=1: stay; wait_cnt increments, saturating at 15.
  - W_ACK: dbg_wr_ack=1 for exactly one cycle, then W_IDLE.
  - dbg_wr_busy=1 in W_PEND and W_ACK. Strobes arriving while busy are ignored.
  - Debug write to r0: no regfile write is issued, but the FSM still passes through W_ACK and the ack pulses.
  - Best-case latency: strobe in cycle t, regfile write in t+1, ack in t+2.
- Starvation:
  - dbg_stall is registered. It sets on the clock edge where wait_cnt==MAX_WAIT-1 and WB wins again.
  - It clears on entry to W_ACK.
  - The pipeline drains bubbles into WB, so wb_wreg eventually drops and the write commits.
- Dump FSM states: D_IDLE, D_READ, D_OUT, D_DONE.
  - D_IDLE: dump_start=1 sets idx=0 and moves to D_READ. dump_start while dump_busy is ignored.
  - D_READ: which_reg=idx. Capture dump_data from reg_content, with a bypass: if rf_wreg=1, rf_destR==idx and idx!=0, capture rf_dest instead. Then D_OUT.
  - D_OUT: dump_valid=1; dump_idx and dump_data are held stable until dump_ready=1.
  - On acceptance with idx<NREG-1: idx+1, back to D_READ. With idx==NREG-1: go to D_DONE.
  - Throughput is 2 cycles per word when ready is held high.
  - D_DONE: dump_done=1 for one cycle, then D_IDLE.
  - dump_busy=1 in every state except D_IDLE.
- Concurrency: the write and dump FSMs run independently in the same cycle. A debug write to the register being read in D_READ is caught by the bypass.
- Widths: idx is 5 bits and never wraps; termination is on NREG-1. wait_cnt is 4 bits and saturates.

Decomposition:
- Shared package holds FSM state encodings (W_IDLE..W_ACK, D_IDLE..D_DONE), REG_ZERO=5'd0 and the default NREG.
- One natural sub-module, regfile_dump_seq: the dump FSM with its index counter and bypass capture.
- Write arbitration and starvation logic stay in the top.

Test Plan:
- Idle pipeline, strobe addr=5 data=32'hDEADBEEF at t: rf_wreg=1, rf_destR=5 at t+1; ack=1 at t+2; a dump then reports word 5 = DEADBEEF.
- wb_wreg held 1 (destR=3) with debug strobe addr=7, MAX_WAIT=8: rf_* follow WB throughout; dbg_stall=1 after 8 lost cycles; drop wb_wreg: debug write issues that cycle, ack next, stall clears with ack.
- Debug write addr=0 data=1: rf_wreg stays 0; ack still pulses; a dump shows r0=0.
- Preload r1..r31 = index*4, dump_start, dump_ready toggling 1/0: exactly 32 transfers in order 0..31 with correct data; data stable while ready=0; one dump_done; 64 cycles when ready is held 1.
- During dump at D_READ idx=9, WB writes r9=32'h12345678: dump word 9 = 12345678.
- Assert rst in W_PEND and mid-dump (idx=12): next cycle all outputs 0, no ack or done; a fresh dump starts from idx 0.
